// File: rtl/snoop_ctrl_mesi_if.sv
// Snoop-side bundle for the MESI snoop controller: the snoop request handshake,
// the data-array read port, the snoop result, the writeback handshake and the
// processor-side local state write port.
interface snoop_ctrl_mesi_if #(
   parameter int IDX_W  = 2,
   parameter int DATA_W = 8,
   parameter int PID_W  = 2
);
   // snoop request
   logic              snoop_valid;
   logic              snoop_ready;
   logic [2:0]        snoop_op;
   logic [PID_W-1:0]  snoop_proc;
   logic [IDX_W-1:0]  snoop_line;
   // data array read port
   logic [IDX_W-1:0]  rd_line;
   logic [DATA_W-1:0] line_data;
   // snoop result
   logic              snoop_done;
   logic              hit;
   logic              abort_mem;
   logic [DATA_W-1:0] data_out;
   logic [PID_W-1:0]  proc_index;
   // writeback handshake
   logic              wb_valid;
   logic              wb_ready;
   logic [DATA_W-1:0] wb_data;
   // local (processor-side) state write
   logic              loc_we;
   logic [IDX_W-1:0]  loc_line;
   logic [1:0]        loc_state;
   logic              loc_stall;

   // Controller side.
   modport slave (
      input  snoop_valid, snoop_op, snoop_proc, snoop_line, line_data,
             wb_ready, loc_we, loc_line, loc_state,
      output snoop_ready, rd_line, snoop_done, hit, abort_mem, data_out,
             proc_index, wb_valid, wb_data, loc_stall
   );

   // Bus / data array / processor side.
   modport master (
      output snoop_valid, snoop_op, snoop_proc, snoop_line, line_data,
             wb_ready, loc_we, loc_line, loc_state,
      input  snoop_ready, rd_line, snoop_done, hit, abort_mem, data_out,
             proc_index, wb_valid, wb_data, loc_stall
   );
endinterface

// File: rtl/snoop_ctrl_mesi.sv
// MESI snoop controller for one private cache. Tracks the coherence state of
// NUM_LINES lines, serves BusRd/BusRdX/BusUpgr snoops through a valid/ready
// handshake and, on a Modified hit, streams the block out through a writeback
// handshake while telling memory to abort its response.
module snoop_ctrl_mesi #(
   parameter int NUM_LINES = 4,
   parameter int DATA_W    = 8,
   parameter int PID_W     = 2,
   parameter int PROC_ID   = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   snoop_ctrl_mesi_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam logic [PID_W-1:0] OWN_ID = PID_W'(PROC_ID);

   localparam logic [2:0] OP_RD   = 3'b001;
   localparam logic [2:0] OP_RDX  = 3'b010;
   localparam logic [2:0] OP_UPGR = 3'b011;

   typedef enum logic [1:0] {ST_I = 2'b00, ST_S = 2'b01, ST_E = 2'b10, ST_M = 2'b11} mesi_e;
   typedef enum logic [1:0] {IDLE, LOOKUP, WB} fsm_e;

   fsm_e              fsm_q, fsm_d;
   logic [2:0]        op_q;
   logic [PID_W-1:0]  proc_q;
   logic [IDX_W-1:0]  line_q;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic              hit_q, abort_q;
   logic [DATA_W-1:0] data_q;
   mesi_e             state_q [NUM_LINES];

   logic              accept;
   logic              loc_ok;
   mesi_e             cur_state;
   mesi_e             lk_next;
   logic              lk_hit, lk_abort;
   logic              done, done_hit, done_abort;
   logic [DATA_W-1:0] done_data;
   logic              st_we;

   assign accept    = bus.snoop_valid && bus.snoop_ready;
   assign cur_state = state_q[line_q];
   // A local write may not touch the line a snoop is currently working on.
   assign bus.loc_stall = bus.loc_we && (fsm_q != IDLE) && (bus.loc_line == line_q);
   assign loc_ok        = bus.loc_we && !bus.loc_stall;

   // Coherence table: next state and hit/abort for the latched snoop.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      lk_next  = cur_state;
      lk_hit   = 1'b0;
      lk_abort = 1'b0;
      if (proc_q != OWN_ID) begin
         case (op_q)
            OP_RD: begin
               if (cur_state != ST_I) begin
                  lk_next  = ST_S;
                  lk_hit   = 1'b1;
                  lk_abort = (cur_state == ST_M);
               end
            end
            OP_RDX: begin
               if (cur_state != ST_I) begin
                  lk_next  = ST_I;
                  lk_hit   = 1'b1;
                  lk_abort = (cur_state == ST_M);
               end
            end
            OP_UPGR: begin
               if (cur_state == ST_S) lk_next = ST_I;
            end
            default: ;
         endcase
      end
   end

   // Snoop FSM: next state, completion pulse and state-array write request.
   always_comb begin
      fsm_d      = fsm_q;
      wb_data_d  = wb_data_q;
      done       = 1'b0;
      done_hit   = 1'b0;
      done_abort = 1'b0;
      done_data  = '0;
      st_we      = 1'b0;
      unique case (fsm_q)
         IDLE: begin
            if (accept) fsm_d = LOOKUP;
         end
         LOOKUP: begin
            if (lk_abort) begin
               // Modified hit: capture the block and hand it to the writeback sink.
               fsm_d     = WB;
               wb_data_d = bus.line_data;
            end else begin
               done      = 1'b1;
               done_hit  = lk_hit;
               done_data = lk_hit ? bus.line_data : '0;
               st_we     = 1'b1;
               fsm_d     = IDLE;
            end
         end
         WB: begin
            // The line is locked against local writes here, so lk_next still
            // reflects the M-state transition decided in LOOKUP.
            if (bus.wb_ready) begin
               done       = 1'b1;
               done_hit   = 1'b1;
               done_abort = 1'b1;
               done_data  = wb_data_q;
               st_we      = 1'b1;
               fsm_d      = IDLE;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   // Control and snoop-context registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fsm_q     <= IDLE;
         op_q      <= '0;
         proc_q    <= '0;
         line_q    <= '0;
         wb_data_q <= '0;
         hit_q     <= 1'b0;
         abort_q   <= 1'b0;
         data_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         fsm_q     <= fsm_d;
         wb_data_q <= wb_data_d;
         if (accept) begin
            op_q   <= bus.snoop_op;
            proc_q <= bus.snoop_proc;
            line_q <= bus.snoop_line;
         end
         if (done) begin
            hit_q   <= done_hit;
            abort_q <= done_abort;
            data_q  <= done_data;
         end
      end
   end

   // Coherence state array; local and snoop writes never target the same line in one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the state array is small and must be all-Invalid after reset, so it is reset explicitly.
         for (int i = 0; i < NUM_LINES; i++) state_q[i] <= ST_I;
      end else begin
         if (loc_ok) state_q[bus.loc_line] <= mesi_e'(bus.loc_state);
         if (st_we)  state_q[line_q]       <= lk_next;
      end
   end

   assign bus.snoop_ready = reset_n && (fsm_q == IDLE);
   assign bus.rd_line     = line_q;
   assign bus.proc_index  = proc_q;
   assign bus.snoop_done  = done;
   assign bus.hit         = done ? done_hit   : hit_q;
   assign bus.abort_mem   = done ? done_abort : abort_q;
   assign bus.data_out    = done ? done_data  : data_q;
   assign bus.wb_valid    = (fsm_q == WB);
   assign bus.wb_data     = wb_data_q;
endmodule

// File: tb/tb_snoop_ctrl_mesi.sv
// Bench for snoop_ctrl_mesi: directed snoops with hand-computed results pushed
// into scoreboard queues; a negedge monitor pops and compares on snoop_done and
// on every writeback cycle.
module tb_snoop_ctrl_mesi;
   localparam logic [2:0] OP_RD   = 3'b001;
   localparam logic [2:0] OP_RDX  = 3'b010;
   localparam logic [2:0] OP_UPGR = 3'b011;
   localparam logic [1:0] ST_I = 2'b00, ST_S = 2'b01, ST_E = 2'b10, ST_M = 2'b11;

   typedef struct {
      logic       hit;
      logic       abort;
      logic [7:0] data;
   } exp_t;

   logic clk;
   logic reset_n;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t       exp_q[$];
   logic [7:0] wb_q[$];
   logic [7:0] mem_data [4];

   snoop_ctrl_mesi_if #(.IDX_W(2), .DATA_W(8), .PID_W(2)) bus ();

   snoop_ctrl_mesi #(.NUM_LINES(4), .DATA_W(8), .PID_W(2), .PROC_ID(0)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data array model: word for the presented line, same cycle.
   always_comb bus.line_data = mem_data[bus.rd_line];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares results and writeback words against the scoreboard.
   always @(negedge clk) begin
      if (reset_n) begin
         if (bus.snoop_done) begin
            if (exp_q.size() == 0) check("unexpected_done", 1, 0);
            else begin
               exp_t e;
               e = exp_q.pop_front();
               check("hit", bus.hit, e.hit);
               check("abort_mem", bus.abort_mem, e.abort);
               if (e.hit) check("data_out", bus.data_out, e.data);
            end
         end
         if (bus.wb_valid) begin
            if (wb_q.size() == 0) check("unexpected_wb", 1, 0);
            else begin
               check("wb_data", bus.wb_data, wb_q[0]);
               if (bus.wb_ready) void'(wb_q.pop_front());
            end
         end
      end
   end

   // Local state write; called and returns at posedge+1.
   task automatic loc_write(input logic [1:0] line, input logic [1:0] st, input logic e_stall);
      bus.loc_we    = 1'b1;
      bus.loc_line  = line;
      bus.loc_state = st;
      @(negedge clk);
      check("loc_stall", bus.loc_stall, e_stall);
      @(posedge clk); #1;
      bus.loc_we = 1'b0;
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (!bus.snoop_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, bus.snoop_ready, 1);
   endtask

   // One snoop transaction; expected results go to the scoreboard first.
   task automatic snoop(input logic [2:0] op, input logic [1:0] proc, input logic [1:0] line,
                        input logic e_hit, input logic e_abort, input logic [7:0] e_data,
                        input int wb_delay);
      exp_t e;
      e.hit = e_hit; e.abort = e_abort; e.data = e_data;
      exp_q.push_back(e);
      if (e_abort) wb_q.push_back(e_data);
      wait_ready("accept_timeout");
      bus.snoop_valid = 1'b1;
      bus.snoop_op    = op;
      bus.snoop_proc  = proc;
      bus.snoop_line  = line;
      @(posedge clk); #1;
      bus.snoop_valid = 1'b0;
      if (!e_abort) begin
         @(negedge clk);
         check("done_latency", bus.snoop_done, 1);
         @(posedge clk); #1;
      end else begin
         @(posedge clk); #1;
         check("wb_valid", bus.wb_valid, 1);
         repeat (wb_delay) begin @(posedge clk); #1; end
         bus.wb_ready = 1'b1;
         @(negedge clk);
         check("wb_done", bus.snoop_done, 1);
         @(posedge clk); #1;
         bus.wb_ready = 1'b0;
      end
      wait_ready("ready_return");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      mem_data[0] = 8'hA0; mem_data[1] = 8'h11; mem_data[2] = 8'h55; mem_data[3] = 8'h3C;
      reset_n = 1'b0;
      bus.snoop_valid = 1'b0; bus.snoop_op = '0; bus.snoop_proc = '0; bus.snoop_line = '0;
      bus.wb_ready = 1'b0; bus.loc_we = 1'b0; bus.loc_line = '0; bus.loc_state = '0;
      repeat (2) @(negedge clk);
      check("rst_ready", bus.snoop_ready, 0);
      check("rst_wb_valid", bus.wb_valid, 0);
      check("rst_done", bus.snoop_done, 0);
      check("rst_hit", bus.hit, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", bus.snoop_ready, 1);
      @(posedge clk); #1;

      // 1: M line, BusRd -> writeback after 3 cycles, line becomes S.
      loc_write(2, ST_M, 0);
      snoop(OP_RD, 1, 2, 1, 1, 8'h55, 3);
      snoop(OP_UPGR, 3, 2, 0, 0, 8'h00, 0);   // S -> I (E would stay)
      snoop(OP_RD, 1, 2, 0, 0, 8'h00, 0);     // proves I

      // 2: E line, BusRdX -> hit, no abort, line becomes I.
      loc_write(0, ST_E, 0);
      snoop(OP_RDX, 2, 0, 1, 0, 8'hA0, 0);
      snoop(OP_RD, 2, 0, 0, 0, 8'h00, 0);

      // 3: S line BusUpgr -> I; I line BusRd -> miss, unchanged.
      loc_write(1, ST_S, 0);
      snoop(OP_UPGR, 1, 1, 0, 0, 8'h00, 0);
      snoop(OP_RD, 1, 1, 0, 0, 8'h00, 0);
      snoop(OP_RD, 2, 1, 0, 0, 8'h00, 0);

      // 4: own-processor snoop on M is ignored; line is still M afterwards.
      loc_write(3, ST_M, 0);
      snoop(OP_RD, 0, 3, 0, 0, 8'h00, 0);
      snoop(OP_RDX, 1, 3, 1, 1, 8'h3C, 0);
      snoop(OP_RD, 1, 3, 0, 0, 8'h00, 0);

      // Unknown op code is a no-op: E stays E, then BusRd hits.
      loc_write(0, ST_E, 0);
      snoop(3'b101, 1, 0, 0, 0, 8'h00, 0);
      snoop(OP_RD, 1, 0, 1, 0, 8'hA0, 0);

      // 5: local writes during a writeback on line 3.
      loc_write(3, ST_M, 0);
      fork
         snoop(OP_RD, 2, 3, 1, 1, 8'h3C, 6);
         begin
            int n = 0;
            while (!bus.wb_valid && n < 10) begin @(posedge clk); #1; n++; end
            check("t5_wb_seen", bus.wb_valid, 1);
            loc_write(3, ST_I, 1);
            loc_write(0, ST_M, 0);
         end
      join
      snoop(OP_RD, 1, 3, 1, 0, 8'h3C, 0);     // line 3 is S
      snoop(OP_RDX, 1, 0, 1, 1, 8'hA0, 1);    // line 0 took the M write

      // 6: reset in the middle of a writeback.
      loc_write(1, ST_M, 0);
      wb_q.push_back(8'h11);
      bus.snoop_valid = 1'b1; bus.snoop_op = OP_RD; bus.snoop_proc = 1; bus.snoop_line = 1;
      @(posedge clk); #1;
      bus.snoop_valid = 1'b0;
      @(posedge clk); #1;
      check("t6_wb_valid", bus.wb_valid, 1);
      reset_n = 1'b0;
      #1;
      check("t6_wb_drop", bus.wb_valid, 0);
      check("t6_no_done", bus.snoop_done, 0);
      wb_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      check("t6_ready", bus.snoop_ready, 1);
      @(posedge clk); #1;
      snoop(OP_RD, 1, 1, 0, 0, 8'h00, 0);
      snoop(OP_RDX, 1, 3, 0, 0, 8'h00, 0);

      repeat (2) @(posedge clk);
      check("exp_q_empty", exp_q.size(), 0);
      check("wb_q_empty", wb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
